// File: rtl/sfp_link_status.sv
// sfp_link_status: per-port SFP+ link qualifier, LED driver and link-down counter.
// Async PHY/cage status is synchronized, debounced into a link state, and decoded
// onto a 2-bit LED (link/fault blink, stretched activity).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ABSENT   | no module in the cage
//   DOWN     | module present, no clean block lock
//   QUALIFY  | clean lock seen, waiting DEBOUNCE_CYCLES before declaring UP
//   UP       | link qualified
//   FAULT    | locked but high BER; LED blinks
//
//   act      | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no activity shown
//   ON       | activity LED lit for BLINK_CYCLES
//   OFF      | forced dark gap of BLINK_CYCLES so bursts stay visible
module sfp_link_status #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int BLINK_CYCLES    = 7812500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  input  logic        sfp_los,
  input  logic        sfp_npres,
  input  logic        rx_activity,
  input  logic        tx_activity,
  output logic        link_up,
  output logic [1:0]  led,
  output logic [2:0]  link_state,
  output logic [15:0] link_down_count
);

  localparam int QW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LOAD = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [BW-1:0] B_LOAD = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [2:0] {
    ST_ABSENT  = 3'd0,
    ST_DOWN    = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_UP      = 3'd3,
    ST_FAULT   = 3'd4
  } link_st_t;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_OFF  = 2'd2
  } act_st_t;

  logic [SYNC_STAGES-1:0] lock_sr, ber_sr, los_sr, npres_sr;
  logic                   lock_s, ber_s, los_s, npres_s;

  link_st_t               state, state_nxt;
  logic [QW-1:0]          qcnt, qcnt_nxt;
  logic                   down_evt;

  logic                   blink_on;
  logic [BW-1:0]          fcnt;

  act_st_t                act_st, act_nxt;
  logic [BW-1:0]          bcnt, bcnt_nxt;
  logic                   pending, pending_nxt;
  logic                   act_pulse;

  // Synchronizers; reset to the "no module, no lock" view of the cage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sr  <= '0;
      ber_sr   <= '0;
      los_sr   <= '1;
      npres_sr <= '1;
    end else begin
      lock_sr  <= {lock_sr[SYNC_STAGES-2:0], rx_block_lock};
      ber_sr   <= {ber_sr[SYNC_STAGES-2:0], rx_high_ber};
      los_sr   <= {los_sr[SYNC_STAGES-2:0], sfp_los};
      npres_sr <= {npres_sr[SYNC_STAGES-2:0], sfp_npres};
    end
  end

  assign lock_s  = lock_sr[SYNC_STAGES-1];
  assign ber_s   = ber_sr[SYNC_STAGES-1];
  assign los_s   = los_sr[SYNC_STAGES-1];
  assign npres_s = npres_sr[SYNC_STAGES-1];

  // Link FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ABSENT;
      qcnt  <= '0;
    end else begin
      state <= state_nxt;
      qcnt  <= qcnt_nxt;
    end
  end

  // Link FSM next state; qcnt counts down from DEBOUNCE_CYCLES-1 to the terminal 0.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    if (npres_s) begin
      state_nxt = ST_ABSENT;
    end else begin
      case (state)
        ST_ABSENT: state_nxt = ST_DOWN;
        ST_DOWN: begin
          if (lock_s && !los_s && !ber_s) begin
            state_nxt = ST_QUALIFY;
            qcnt_nxt  = Q_LOAD;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s || los_s || ber_s) state_nxt = ST_DOWN;
          else if (qcnt == '0)           state_nxt = ST_UP;
          else                           qcnt_nxt  = qcnt - Q_ONE;
        end
        ST_UP: begin
          if (!lock_s || los_s) state_nxt = ST_DOWN;
          else if (ber_s)       state_nxt = ST_FAULT;
        end
        ST_FAULT: begin
          if (!lock_s || los_s) begin
            state_nxt = ST_DOWN;
          end else if (!ber_s) begin
            state_nxt = ST_QUALIFY;
            qcnt_nxt  = Q_LOAD;
          end
        end
        default: state_nxt = ST_ABSENT;
      endcase
    end
  end

  assign down_evt = ((state == ST_UP) || (state == ST_FAULT)) &&
                    ((state_nxt == ST_DOWN) || (state_nxt == ST_ABSENT));

  // Saturating count of qualified-link losses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_down_count <= '0;
    end else if (down_evt && (link_down_count != 16'hFFFF)) begin
      link_down_count <= link_down_count + 16'd1;
    end
  end

  // Fault blink: lit on FAULT entry, toggles each time the down-counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_on <= 1'b0;
      fcnt     <= '0;
    end else if (state_nxt == ST_FAULT) begin
      if (state != ST_FAULT) begin
        blink_on <= 1'b1;
        fcnt     <= B_LOAD;
      end else if (fcnt == '0) begin
        blink_on <= ~blink_on;
        fcnt     <= B_LOAD;
      end else begin
        fcnt <= fcnt - B_ONE;
      end
    end else begin
      blink_on <= 1'b0;
      fcnt     <= '0;
    end
  end

  assign act_pulse = (rx_activity || tx_activity) && (state == ST_UP);

  // Activity stretcher registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_st  <= ACT_IDLE;
      bcnt    <= '0;
      pending <= 1'b0;
    end else begin
      act_st  <= act_nxt;
      bcnt    <= bcnt_nxt;
      pending <= pending_nxt;
    end
  end

  // Activity stretcher next state; dropping out of UP parks it dark immediately.
  always_comb begin
    act_nxt     = act_st;
    bcnt_nxt    = bcnt;
    pending_nxt = pending;
    if (state_nxt != ST_UP) begin
      act_nxt     = ACT_IDLE;
      bcnt_nxt    = '0;
      pending_nxt = 1'b0;
    end else begin
      case (act_st)
        ACT_IDLE: begin
          if (act_pulse) begin
            act_nxt  = ACT_ON;
            bcnt_nxt = B_LOAD;
          end
        end
        ACT_ON: begin
          if (act_pulse) pending_nxt = 1'b1;
          if (bcnt == '0) begin
            act_nxt  = ACT_OFF;
            bcnt_nxt = B_LOAD;
          end else begin
            bcnt_nxt = bcnt - B_ONE;
          end
        end
        ACT_OFF: begin
          if (bcnt == '0) begin
            pending_nxt = 1'b0;
            if (pending || act_pulse) begin
              act_nxt  = ACT_ON;
              bcnt_nxt = B_LOAD;
            end else begin
              act_nxt = ACT_IDLE;
            end
          end else begin
            bcnt_nxt = bcnt - B_ONE;
            if (act_pulse) pending_nxt = 1'b1;
          end
        end
        default: act_nxt = ACT_IDLE;
      endcase
    end
  end

  assign link_state = state;
  assign link_up    = (state == ST_UP);
  assign led        = {(act_st == ACT_ON),
                       (state == ST_UP) || ((state == ST_FAULT) && blink_on)};

endmodule

// File: tb/tb_sfp_link_status.sv
// Directed bench for sfp_link_status with short debounce/blink periods.
module tb_sfp_link_status;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock, ber, los, npres, rx_act, tx_act;
  logic        link_up;
  logic [1:0]  led;
  logic [2:0]  link_state;
  logic [15:0] link_down_count;

  int checks   = 0;
  int failures = 0;

  sfp_link_status #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .BLINK_CYCLES   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_block_lock  (lock),
    .rx_high_ber    (ber),
    .sfp_los        (los),
    .sfp_npres      (npres),
    .rx_activity    (rx_act),
    .tx_activity    (tx_act),
    .link_up        (link_up),
    .led            (led),
    .link_state     (link_state),
    .link_down_count(link_down_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reset just released at a negedge with a present, locked, clean module.
  task automatic bring_up(input string ph);
    cyc(2);  chk({ph, "_st_e2"}, 32'(link_state), 0);
    cyc(1);  chk({ph, "_st_e3"}, 32'(link_state), 1);
    cyc(1);  chk({ph, "_st_e4"}, 32'(link_state), 2);
    cyc(7);  chk({ph, "_up_e11"}, 32'(link_up), 0);
             chk({ph, "_st_e11"}, 32'(link_state), 2);
    cyc(1);  chk({ph, "_up_e12"}, 32'(link_up), 1);
             chk({ph, "_st_e12"}, 32'(link_state), 3);
             chk({ph, "_led_up"}, 32'(led), 1);
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b1; ber = 1'b0; los = 1'b0; npres = 1'b0;
    rx_act = 1'b0; tx_act = 1'b0;

    // T1 reset state and bring-up timing
    cyc(3);
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_state", 32'(link_state), 0);
    chk("rst_count", 32'(link_down_count), 0);
    rst_n = 1'b1;
    bring_up("t1");
    chk("t1_count", 32'(link_down_count), 0);

    // T2 lock loss from UP, then a glitch in the middle of qualification
    lock = 1'b0;
    cyc(2); chk("t2_st_hold", 32'(link_state), 3);
    cyc(1); chk("t2_st_down", 32'(link_state), 1);
            chk("t2_count1", 32'(link_down_count), 1);
    lock = 1'b1;
    cyc(2); chk("t2_st_down2", 32'(link_state), 1);
    cyc(1); chk("t2_st_qual", 32'(link_state), 2);
    cyc(3);
    lock = 1'b0;
    cyc(2); chk("t2_st_qual5", 32'(link_state), 2);
    cyc(1); chk("t2_st_glitch", 32'(link_state), 1);
            chk("t2_up_glitch", 32'(link_up), 0);
    lock = 1'b1;
    cyc(2); chk("t2_st_down3", 32'(link_state), 1);
    cyc(1); chk("t2_st_requal", 32'(link_state), 2);
    cyc(7); chk("t2_up_early", 32'(link_up), 0);
    cyc(1); chk("t2_up", 32'(link_up), 1);
            chk("t2_count", 32'(link_down_count), 1);

    // T3 high BER -> FAULT blink -> requalify
    ber = 1'b1;
    cyc(2); chk("t3_st_hold", 32'(link_state), 3);
    cyc(1); chk("t3_st_fault", 32'(link_state), 4);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3_blink%0d", i), 32'(led[0]), ((i / 4) % 2 == 0) ? 1 : 0);
      cyc(1);
    end
    chk("t3_count", 32'(link_down_count), 1);
    ber = 1'b0;
    cyc(2); chk("t3_st_fault2", 32'(link_state), 4);
    cyc(1); chk("t3_st_qual", 32'(link_state), 2);
    cyc(7); chk("t3_st_qual7", 32'(link_state), 2);
    cyc(1); chk("t3_st_up", 32'(link_state), 3);

    // T4 activity stretcher
    rx_act = 1'b1;
    cyc(1);
    rx_act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_single%0d", i), 32'(led), (i < 4) ? 3 : 1);
      cyc(1);
    end
    rx_act = 1'b1; tx_act = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_cont%0d", i), 32'(led), ((i % 8) < 4) ? 3 : 1);
      cyc(1);
    end
    rx_act = 1'b0; tx_act = 1'b0;
    los = 1'b1;
    cyc(2); chk("t4_st_hold", 32'(link_state), 3);
    cyc(1); chk("t4_st_los", 32'(link_state), 1);
            chk("t4_count", 32'(link_down_count), 2);
    cyc(1); chk("t4_led_down", 32'(led), 0);
    rx_act = 1'b1; tx_act = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_down_act%0d", i), 32'(led), 0);
      cyc(1);
    end
    rx_act = 1'b0; tx_act = 1'b0;
    los = 1'b0;
    cyc(3); chk("t4_st_qual", 32'(link_state), 2);
    cyc(8); chk("t4_st_up", 32'(link_state), 3);

    // T5 module removal and counter saturation
    npres = 1'b1;
    cyc(2); chk("t5_st_hold", 32'(link_state), 3);
    cyc(1); chk("t5_st_absent", 32'(link_state), 0);
            chk("t5_led", 32'(led), 0);
            chk("t5_link_up", 32'(link_up), 0);
            chk("t5_count3", 32'(link_down_count), 3);
    npres = 1'b0;
    cyc(3); chk("t5_st_down", 32'(link_state), 1);
    cyc(9); chk("t5_st_up", 32'(link_state), 3);
    force dut.link_down_count = 16'hFFFE;
    #1;
    release dut.link_down_count;
    #1;
    chk("t5_preload", 32'(link_down_count), 32'h0000FFFE);
    npres = 1'b1;
    cyc(3); chk("t5_st_absent2", 32'(link_state), 0);
            chk("t5_count_max", 32'(link_down_count), 32'h0000FFFF);
    npres = 1'b0;
    cyc(3); chk("t5_st_down2", 32'(link_state), 1);
    cyc(9); chk("t5_st_up2", 32'(link_state), 3);
    npres = 1'b1;
    cyc(3); chk("t5_st_absent3", 32'(link_state), 0);
            chk("t5_count_sat", 32'(link_down_count), 32'h0000FFFF);

    // T6 async reset while in FAULT with activity present
    npres = 1'b0;
    cyc(12); chk("t6_st_up", 32'(link_state), 3);
    ber = 1'b1; rx_act = 1'b1; tx_act = 1'b1;
    cyc(3); chk("t6_st_fault", 32'(link_state), 4);
    cyc(1); chk("t6_led_fault", 32'(led), 1);
            chk("t6_count_pre", 32'(link_down_count), 32'h0000FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_link_up", 32'(link_up), 0);
    chk("t6_rst_led", 32'(led), 0);
    chk("t6_rst_state", 32'(link_state), 0);
    chk("t6_rst_count", 32'(link_down_count), 0);
    ber = 1'b0; rx_act = 1'b0; tx_act = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    bring_up("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
